// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
// Shared types and constants for the ALU sequencer.
//   state_t : sequencer FSM states
//   op_t    : operation select (MUL / ADD16)
//   ALU_W   : width of the shared adder ALU
package alu_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, MUL_RUN, ADD_LO, ADD_HI, DONE} state_t;

  typedef enum logic {OP_MUL = 1'b0, OP_ADD16 = 1'b1} op_t;

  localparam int ALU_W = 8;

endpackage

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl
// Multi-cycle sequencer that drives an external WIDTH-bit adder ALU to run
// either an unsigned WIDTHxWIDTH shift-add multiply or a 2*WIDTH-bit add
// built as a two-limb carry chain.
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   start, op           request (accepted only when ready) and op select
//   op_a, op_b          2*WIDTH-bit operands, latched on accept
//   ready               high while idle
//   done                one-cycle pulse when result/carry become valid
//   result, carry       registered outcome, held until the next done
//   alu_a/alu_b/alu_cin registered drive into the external ALU
//   alu_sum/alu_cout    combinational answer from the external ALU
//
// All outputs are registers. The ALU drive for a cycle is prepared on the
// edge that enters that cycle's state, so the ALU answer is available in the
// same cycle and is consumed on the edge that leaves it.
module alu_seq_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH    = ALU_W,
  parameter int MUL_ITER = WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               op,
  input  logic [2*WIDTH-1:0] op_a,
  input  logic [2*WIDTH-1:0] op_b,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic               alu_cin,
  input  logic [WIDTH-1:0]   alu_sum,
  input  logic               alu_cout
);

  localparam int CNT_W = $clog2(MUL_ITER) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITER - 1);
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

  state_t               state_r, state_s;
  logic [WIDTH-1:0]     m_r, m_s;          // multiplicand
  logic [WIDTH-1:0]     q_r, q_s;          // multiplier / low product bits
  logic [WIDTH-1:0]     acc_r, acc_s;      // partial-product high half
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic [WIDTH-1:0]     a_hi_r, a_hi_s;    // upper limbs for ADD16
  logic [WIDTH-1:0]     b_hi_r, b_hi_s;
  logic [WIDTH-1:0]     lo_r, lo_s;        // low limb of the ADD16 sum
  logic [2*WIDTH-1:0]   result_r, result_s;
  logic                 carry_r, carry_s;
  logic                 done_r, done_s;
  logic                 ready_r, ready_s;
  logic [WIDTH-1:0]     alu_a_r, alu_a_s;
  logic [WIDTH-1:0]     alu_b_r, alu_b_s;
  logic                 alu_cin_r, alu_cin_s;

  assign ready   = ready_r;
  assign done    = done_r;
  assign result  = result_r;
  assign carry   = carry_r;
  assign alu_a   = alu_a_r;
  assign alu_b   = alu_b_r;
  assign alu_cin = alu_cin_r;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      m_r       <= ZERO_W;
      q_r       <= ZERO_W;
      acc_r     <= ZERO_W;
      cnt_r     <= {CNT_W{1'b0}};
      a_hi_r    <= ZERO_W;
      b_hi_r    <= ZERO_W;
      lo_r      <= ZERO_W;
      result_r  <= {2*WIDTH{1'b0}};
      carry_r   <= 1'b0;
      done_r    <= 1'b0;
      ready_r   <= 1'b1;
      alu_a_r   <= ZERO_W;
      alu_b_r   <= ZERO_W;
      alu_cin_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      m_r       <= m_s;
      q_r       <= q_s;
      acc_r     <= acc_s;
      cnt_r     <= cnt_s;
      a_hi_r    <= a_hi_s;
      b_hi_r    <= b_hi_s;
      lo_r      <= lo_s;
      result_r  <= result_s;
      carry_r   <= carry_s;
      done_r    <= done_s;
      ready_r   <= ready_s;
      alu_a_r   <= alu_a_s;
      alu_b_r   <= alu_b_s;
      alu_cin_r <= alu_cin_s;
    end
  end

  // Next-state, datapath update and next-cycle ALU drive.
  always_comb begin
    state_s   = state_r;
    m_s       = m_r;
    q_s       = q_r;
    acc_s     = acc_r;
    cnt_s     = cnt_r;
    a_hi_s    = a_hi_r;
    b_hi_s    = b_hi_r;
    lo_s      = lo_r;
    result_s  = result_r;
    carry_s   = carry_r;
    done_s    = 1'b0;
    alu_a_s   = ZERO_W;
    alu_b_s   = ZERO_W;
    alu_cin_s = 1'b0;

    case (state_r)
      IDLE: begin
        if (start) begin
          if (op_t'(op) == OP_MUL) begin
            m_s     = op_a[WIDTH-1:0];
            q_s     = op_b[WIDTH-1:0];
            acc_s   = ZERO_W;
            cnt_s   = {CNT_W{1'b0}};
            state_s = MUL_RUN;
            // First iteration: ACC is zero, addend gated by multiplier LSB.
            alu_a_s = ZERO_W;
            alu_b_s = op_b[0] ? op_a[WIDTH-1:0] : ZERO_W;
          end else begin
            a_hi_s  = op_a[2*WIDTH-1:WIDTH];
            b_hi_s  = op_b[2*WIDTH-1:WIDTH];
            state_s = ADD_LO;
            alu_a_s = op_a[WIDTH-1:0];
            alu_b_s = op_b[WIDTH-1:0];
          end
        end else begin
          state_s = IDLE;
        end
      end

      MUL_RUN: begin
        // The 9-bit ALU answer shifts right across {ACC,Q}.
        acc_s = {alu_cout, alu_sum[WIDTH-1:1]};
        q_s   = {alu_sum[0], q_r[WIDTH-1:1]};
        cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_r == CNT_LAST) begin
          state_s  = DONE;
          result_s = {acc_s, q_s};
          carry_s  = 1'b0;
          done_s   = 1'b1;
        end else begin
          alu_a_s = acc_s;
          alu_b_s = q_s[0] ? m_r : ZERO_W;
        end
      end

      ADD_LO: begin
        lo_s      = alu_sum;
        state_s   = ADD_HI;
        alu_a_s   = a_hi_r;
        alu_b_s   = b_hi_r;
        // The registered carry-in doubles as the inter-limb carry.
        alu_cin_s = alu_cout;
      end

      ADD_HI: begin
        result_s = {alu_sum, lo_r};
        carry_s  = alu_cout;
        done_s   = 1'b1;
        state_s  = DONE;
      end

      DONE: begin
        state_s = IDLE;
      end

      default: begin
        state_s = IDLE;
      end
    endcase

    ready_s = (state_s == IDLE);
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl
// Directed self-checking bench for alu_seq_ctrl. A behavioural 8-bit adder
// stands in for the external ALU. Inputs change on the falling edge and
// outputs are sampled on the falling edge.
module tb_alu_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        ready;
  logic        done;
  logic [15:0] result;
  logic        carry;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_cin;
  logic [7:0]  alu_sum;
  logic        alu_cout;

  int checks;
  int errors;

  logic [7:0]  tr_b   [0:20];
  logic        tr_cin [0:20];
  logic [15:0] res_c1;

  alu_seq_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .op_a     (op_a),
    .op_b     (op_b),
    .ready    (ready),
    .done     (done),
    .result   (result),
    .carry    (carry),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_cin  (alu_cin),
    .alu_sum  (alu_sum),
    .alu_cout (alu_cout)
  );

  // Behavioural stand-in for the external ALU.
  assign {alu_cout, alu_sum} = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one op from idle, scramble the operand inputs after accept, and
  // return the cycle number (accept cycle = 0) in which done is seen.
  task automatic run_op(input logic o, input logic [15:0] a, input logic [15:0] b,
                        output int lat);
    start = 1'b1;
    op    = o;
    op_a  = a;
    op_b  = b;
    step();
    start = 1'b0;
    op_a  = 16'hA5A5;
    op_b  = 16'h5A5A;
    lat   = 0;
    for (int n = 1; n <= 20; n++) begin
      tr_b[n]   = alu_b;
      tr_cin[n] = alu_cin;
      if (n == 1) res_c1 = result;
      if (done) begin
        lat = n;
        break;
      end
      step();
    end
  endtask

  typedef struct {
    logic        o;
    logic [15:0] a;
    logic [15:0] b;
    int          lat;
    logic [15:0] res;
    logic        cy;
  } vec_t;

  vec_t vecs [0:6];

  initial begin
    int lat;
    int ndone;
    logic [15:0] prev;
    logic [7:0]  exp_b [1:8];

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    op     = 1'b0;
    op_a   = 16'h0000;
    op_b   = 16'h0000;

    vecs[0] = '{1'b0, 16'h000D, 16'h000B, 9, 16'h008F, 1'b0};
    vecs[1] = '{1'b0, 16'h00FF, 16'h00FF, 9, 16'hFE01, 1'b0};
    vecs[2] = '{1'b0, 16'h0080, 16'h0000, 9, 16'h0000, 1'b0};
    vecs[3] = '{1'b0, 16'hAB01, 16'h77C8, 9, 16'h00C8, 1'b0};
    vecs[4] = '{1'b1, 16'h00FF, 16'h0001, 3, 16'h0100, 1'b0};
    vecs[5] = '{1'b1, 16'hFFFF, 16'h0001, 3, 16'h0000, 1'b1};
    vecs[6] = '{1'b1, 16'h1234, 16'h4321, 3, 16'h5555, 1'b0};

    exp_b[1] = 8'd13; exp_b[2] = 8'd13; exp_b[3] = 8'd0; exp_b[4] = 8'd13;
    exp_b[5] = 8'd0;  exp_b[6] = 8'd0;  exp_b[7] = 8'd0; exp_b[8] = 8'd0;

    @(negedge clk);
    step();
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", {16'd0, result}, 32'd0);
    check("rst_carry", {31'd0, carry}, 32'd0);
    check("rst_alu", {15'd0, alu_a, alu_b, alu_cin}, 32'd0);
    rst_n = 1'b1;
    step();

    prev = 16'h0000;
    for (int i = 0; i <= 6; i++) begin
      run_op(vecs[i].o, vecs[i].a, vecs[i].b, lat);
      check($sformatf("lat%0d", i), lat, vecs[i].lat);
      check($sformatf("res%0d", i), {16'd0, result}, {16'd0, vecs[i].res});
      check($sformatf("cy%0d", i), {31'd0, carry}, {31'd0, vecs[i].cy});
      check($sformatf("ready_done%0d", i), {31'd0, ready}, 32'd0);
      check($sformatf("held%0d", i), {16'd0, res_c1}, {16'd0, prev});
      if (i == 0) begin
        for (int k = 1; k <= 8; k++)
          check($sformatf("mul_alu_b%0d", k), {24'd0, tr_b[k]}, {24'd0, exp_b[k]});
      end
      if (i == 4) begin
        check("add_cin_lo", {31'd0, tr_cin[1]}, 32'd0);
        check("add_cin_hi", {31'd0, tr_cin[2]}, 32'd1);
      end
      prev = vecs[i].res;
      step();
      check($sformatf("pulse%0d", i), {31'd0, done}, 32'd0);
      check($sformatf("ready_idle%0d", i), {31'd0, ready}, 32'd1);
    end

    // start held high; op_a changed mid-run must not disturb the operation.
    start = 1'b1;
    op    = 1'b0;
    op_a  = 16'h0007;
    op_b  = 16'h0006;
    ndone = 0;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (n == 4) op_a = 16'h00FF;
      if (done) ndone++;
      if (n == 9) begin
        check("hold_res", {16'd0, result}, 32'd42);
        check("hold_cy", {31'd0, carry}, 32'd0);
      end
    end
    check("hold_ndone", ndone, 1);
    check("hold_ready10", {31'd0, ready}, 32'd1);
    step();
    check("hold_accept", {31'd0, ready}, 32'd0);
    start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      step();
    end
    check("hold2_lat", lat, 9);
    check("hold2_res", {16'd0, result}, 32'h05FA);
    step();

    // Reset in cycle 4 of a MUL aborts it.
    start = 1'b1;
    op    = 1'b0;
    op_a  = 16'h0009;
    op_b  = 16'h0009;
    step();
    start = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    step();
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", {16'd0, result}, 32'd0);
    check("abort_alu", {15'd0, alu_a, alu_b, alu_cin}, 32'd0);
    rst_n = 1'b1;
    ndone = 0;
    for (int n = 0; n < 12; n++) begin
      if (done) ndone++;
      step();
    end
    check("abort_nodone", ndone, 0);
    run_op(1'b1, 16'h0002, 16'h0003, lat);
    check("post_lat", lat, 3);
    check("post_res", {16'd0, result}, 32'd5);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
